// File: rtl/vscale_mem_arbiter.sv
// Two-master (imem/dmem) to one-slave arbiter for a pipelined memory port.
// Default build uses dmem priority with an imem anti-starvation override; define VSCALE_ARB_RR_EN for round-robin.
module vscale_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int BUS_WIDTH    = 32,
  parameter int SIZE_WIDTH   = 3,
  parameter int RESP_WIDTH   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_read,
  input  logic [SIZE_WIDTH-1:0] m0_size,
  output logic [BUS_WIDTH-1:0]  m0_rdata,
  output logic                  m0_ready,
  output logic [RESP_WIDTH-1:0] m0_resp,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [SIZE_WIDTH-1:0] m1_size,
  input  logic [BUS_WIDTH-1:0]  m1_wdata,
  output logic [BUS_WIDTH-1:0]  m1_rdata,
  output logic                  m1_ready,
  output logic [RESP_WIDTH-1:0] m1_resp,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic                  s_read,
  output logic                  s_write,
  output logic [SIZE_WIDTH-1:0] s_size,
  output logic [BUS_WIDTH-1:0]  s_wdata,
  input  logic [BUS_WIDTH-1:0]  s_rdata,
  input  logic                  s_ready,
  input  logic [RESP_WIDTH-1:0] s_resp
);

  // state   | meaning
  // DP_IDLE | no data phase in flight
  // DP_M0   | imem owns the current data phase
  // DP_M1   | dmem owns the current data phase
  typedef enum logic [1:0] {DP_IDLE = 2'd0, DP_M0 = 2'd1, DP_M1 = 2'd2} dp_t;
  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_M0 = 2'd1, GNT_M1 = 2'd2} gnt_t;

  logic req0, req1;
  gnt_t gnt_new, gnt, gnt_q;
  dp_t  dp_state, dp_next;

  assign req0 = m0_read;
  assign req1 = m1_read | m1_write;

`ifdef VSCALE_ARB_RR_EN
  logic last_m1;

  always_comb begin
    gnt_new = GNT_NONE;
    if (req0 && req1)
      gnt_new = last_m1 ? GNT_M0 : GNT_M1;
    else if (req1)
      gnt_new = GNT_M1;
    else if (req0)
      gnt_new = GNT_M0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_m1 <= 1'b1;
    else if (s_ready && gnt != GNT_NONE)
      last_m1 <= (gnt == GNT_M1);
  end
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  always_comb begin
    gnt_new = GNT_NONE;
    if (req0 && starve_cnt == STARVE_MAX)
      gnt_new = GNT_M0;
    else if (req1)
      gnt_new = GNT_M1;
    else if (req0)
      gnt_new = GNT_M0;
  end

  // Counts accepted cycles in which imem asked but dmem was granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      starve_cnt <= 4'd0;
    else if (!req0)
      starve_cnt <= 4'd0;
    else if (s_ready) begin
      if (gnt == GNT_M0)
        starve_cnt <= 4'd0;
      else if (gnt == GNT_M1 && starve_cnt < STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  // A stalled slave keeps the address phase frozen on the previous owner.
  assign gnt = s_ready ? gnt_new : gnt_q;

  always_comb begin
    dp_next = dp_state;
    if (s_ready) begin
      case (gnt)
        GNT_M0:  dp_next = DP_M0;
        GNT_M1:  dp_next = DP_M1;
        default: dp_next = DP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q    <= GNT_NONE;
      dp_state <= DP_IDLE;
    end else begin
      gnt_q    <= gnt;
      dp_state <= dp_next;
    end
  end

  always_comb begin
    s_addr  = '0;
    s_size  = '0;
    s_read  = 1'b0;
    s_write = 1'b0;
    if (reset) begin
      case (gnt)
        GNT_M0: begin
          s_addr = m0_addr;
          s_size = m0_size;
          s_read = m0_read;
        end
        GNT_M1: begin
          s_addr  = m1_addr;
          s_size  = m1_size;
          s_read  = m1_read;
          s_write = m1_write;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_wdata  = '0;
    m0_rdata = '0;
    m0_resp  = '0;
    m1_rdata = '0;
    m1_resp  = '0;
    if (reset) begin
      case (dp_state)
        DP_M0: begin
          m0_rdata = s_rdata;
          m0_resp  = s_resp;
        end
        DP_M1: begin
          m1_rdata = s_rdata;
          m1_resp  = s_resp;
          s_wdata  = m1_wdata;
        end
        default: ;
      endcase
    end
  end

  assign m0_ready = reset & s_ready & ~(req0 & (gnt != GNT_M0));
  assign m1_ready = reset & s_ready & ~(req1 & (gnt != GNT_M1));

endmodule
